cpl_checker: RTL and testbench

- Completion checker that sits directly downstream of the PIO controller.
- Consumes the controller's expectation outputs (rx_type, rx_tag, rx_data) and the Requester Completion (RC) AXI4-Stream from the PCIe core.
- Reports rx_success / rx_fail pulses back to the controller.
- Parses RC descriptors, matches tags, checks status, poison and first data DW, and runs a completion timeout.

---
 rtl/cpl_checker.sv | 246 ++++++++++++++++++++++++
 tb/tb_cpl_checker.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpl_checker.sv
// Completion checker for the PIO controller.
// Watches the Requester Completion stream for the completion the controller
// expects and reports a one-cycle rx_success or rx_fail pulse. Completions
// that match no outstanding request are counted in unexp_cnt.
module cpl_checker #(
  parameter int          TCQ            = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned UNEXP_W        = 16
) (
  input  logic               user_clk,
  input  logic               reset_n,
  input  logic               tx_start,
  input  logic               rx_type,
  input  logic [7:0]         rx_tag,
  input  logic [31:0]        rx_data,
  input  logic [127:0]       rc_tdata,
  input  logic [3:0]         rc_tkeep,
  input  logic               rc_tlast,
  input  logic               rc_tvalid,
  output logic               rc_tready,
  output logic               rx_success,
  output logic               rx_fail,
  output logic [2:0]         fail_code,
  output logic [UNEXP_W-1:0] unexp_cnt,
  output logic               armed
);

  localparam int unsigned        CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   TMO_LOAD  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [UNEXP_W-1:0] UNEXP_MAX = '1;

  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_STATUS  = 3'd1;
  localparam logic [2:0] FC_POISON  = 3'd2;
  localparam logic [2:0] FC_ERRCODE = 3'd3;
  localparam logic [2:0] FC_TYPE    = 3'd4;
  localparam logic [2:0] FC_DATA    = 3'd5;
  localparam logic [2:0] FC_TIMEOUT = 3'd6;

  // TCQ only models clock-to-out in behavioural sims; it has no effect here.
  if (TIMEOUT_CYCLES < 2 || TCQ < 0) begin : g_param_check
    $error("cpl_checker: TIMEOUT_CYCLES must be >= 2 and TCQ non-negative");
  end

  // REPORT is not a separate state: the verdict is taken on the tlast beat
  // and registered, so the pulse cycle is the report cycle.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_HDR,
    ST_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic                 sof_q, sof_d;
  logic                 exp_type_q, exp_type_d;
  logic [7:0]           exp_tag_q, exp_tag_d;
  logic [31:0]          exp_data_q, exp_data_d;
  logic                 first_frag_q, first_frag_d;
  logic [2:0]           err_q, err_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic                 armed_q, armed_d;
  logic                 rc_tready_q, rc_tready_d;
  logic                 rx_success_q, rx_success_d;
  logic                 rx_fail_q, rx_fail_d;
  logic [2:0]           fail_code_q, fail_code_d;
  logic [UNEXP_W-1:0]   unexp_q, unexp_d;

  logic                 beat;
  logic                 term;
  logic [2:0]           term_code;
  logic [2:0]           chk_code;

  // Descriptor fields, meaningful only on the first beat of a TLP.
  logic [3:0]  d_err;
  logic        d_done;
  logic [10:0] d_dwc;
  logic [2:0]  d_status;
  logic        d_poison;
  logic [7:0]  d_tag;
  logic [31:0] d_data;

  assign d_err    = rc_tdata[15:12];
  assign d_done   = rc_tdata[30];
  assign d_dwc    = rc_tdata[42:32];
  assign d_status = rc_tdata[45:43];
  assign d_poison = rc_tdata[46];
  assign d_tag    = rc_tdata[71:64];
  assign d_data   = rc_tdata[127:96];

  logic unused_ok;
  assign unused_ok = ^{rc_tdata[11:0], rc_tdata[29:16], rc_tdata[31],
                       rc_tdata[63:47], rc_tdata[95:72], rc_tkeep[2:0]};

  assign beat = rc_tvalid && rc_tready_q;

  // Prioritised header checks for a tag-matched first beat.
  always_comb begin
    chk_code = FC_NONE;
    if (d_status != 3'd0) begin
      chk_code = FC_STATUS;
    end else if (d_poison) begin
      chk_code = FC_POISON;
    end else if (d_err != 4'd0) begin
      chk_code = FC_ERRCODE;
    end else if (exp_type_q != (d_dwc != 11'd0)) begin
      chk_code = FC_TYPE;
    end else if (exp_type_q && first_frag_q && rc_tkeep[3] && (d_data != exp_data_q)) begin
      chk_code = FC_DATA;
    end
  end

  // Next-state: TLP framing, tag match, verdict, timeout, then (re-)arm.
  always_comb begin
    state_d      = state_q;
    sof_d        = sof_q;
    exp_type_d   = exp_type_q;
    exp_tag_d    = exp_tag_q;
    exp_data_d   = exp_data_q;
    first_frag_d = first_frag_q;
    err_d        = err_q;
    done_d       = done_q;
    tmo_d        = tmo_q;
    armed_d      = armed_q;
    rc_tready_d  = 1'b1;
    rx_success_d = 1'b0;
    rx_fail_d    = 1'b0;
    fail_code_d  = fail_code_q;
    unexp_d      = unexp_q;
    term         = 1'b0;
    term_code    = FC_NONE;

    if (beat) begin
      sof_d = rc_tlast;
      if (sof_q) begin
        if (state_q == ST_WAIT_HDR && d_tag == exp_tag_q) begin
          if (rc_tlast) begin
            if (chk_code != FC_NONE || d_done) begin
              term      = 1'b1;
              term_code = chk_code;
            end else begin
              first_frag_d = 1'b0;
            end
          end else begin
            state_d = ST_DRAIN;
            err_d   = chk_code;
            done_d  = d_done;
          end
        end else if (unexp_q != UNEXP_MAX) begin
          unexp_d = unexp_q + 1'b1;
        end
      end else if (state_q == ST_DRAIN && rc_tlast) begin
        if (err_q != FC_NONE || done_q) begin
          term      = 1'b1;
          term_code = err_q;
        end else begin
          state_d      = ST_WAIT_HDR;
          first_frag_d = 1'b0;
        end
      end
    end

    if (term) begin
      state_d = ST_IDLE;
      armed_d = 1'b0;
      tmo_d   = '0;
      if (term_code != FC_NONE) begin
        rx_fail_d   = 1'b1;
        fail_code_d = term_code;
      end else begin
        rx_success_d = 1'b1;
      end
    end else if (armed_q) begin
      if (tmo_q == CNT_W'(1)) begin
        state_d     = ST_IDLE;
        armed_d     = 1'b0;
        tmo_d       = '0;
        rx_fail_d   = 1'b1;
        fail_code_d = FC_TIMEOUT;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end

    // A new launch overrides the old request; any verdict above still pulses.
    if (tx_start) begin
      state_d      = ST_WAIT_HDR;
      exp_type_d   = rx_type;
      exp_tag_d    = rx_tag;
      exp_data_d   = rx_data;
      first_frag_d = 1'b1;
      err_d        = FC_NONE;
      done_d       = 1'b0;
      tmo_d        = TMO_LOAD;
      armed_d      = 1'b1;
      if (!rx_fail_d) begin
        fail_code_d = FC_NONE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sof_q        <= 1'b1;
      exp_type_q   <= 1'b0;
      exp_tag_q    <= '0;
      exp_data_q   <= '0;
      first_frag_q <= 1'b0;
      err_q        <= FC_NONE;
      done_q       <= 1'b0;
      tmo_q        <= '0;
      armed_q      <= 1'b0;
      rc_tready_q  <= 1'b0;
      rx_success_q <= 1'b0;
      rx_fail_q    <= 1'b0;
      fail_code_q  <= FC_NONE;
      unexp_q      <= '0;
    end else begin
      state_q      <= state_d;
      sof_q        <= sof_d;
      exp_type_q   <= exp_type_d;
      exp_tag_q    <= exp_tag_d;
      exp_data_q   <= exp_data_d;
      first_frag_q <= first_frag_d;
      err_q        <= err_d;
      done_q       <= done_d;
      tmo_q        <= tmo_d;
      armed_q      <= armed_d;
      rc_tready_q  <= rc_tready_d;
      rx_success_q <= rx_success_d;
      rx_fail_q    <= rx_fail_d;
      fail_code_q  <= fail_code_d;
      unexp_q      <= unexp_d;
    end
  end

  assign rc_tready  = rc_tready_q;
  assign rx_success = rx_success_q;
  assign rx_fail    = rx_fail_q;
  assign fail_code  = fail_code_q;
  assign unexp_cnt  = unexp_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_cpl_checker.sv
// Bench for cpl_checker: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction model.
module tb_cpl_checker;

  localparam int unsigned    T    = 100;
  localparam int unsigned    UW   = 4;
  localparam int unsigned    UMAX = (1 << UW) - 1;

  logic           user_clk  = 1'b0;
  logic           reset_n   = 1'b1;
  logic           tx_start  = 1'b0;
  logic           rx_type   = 1'b0;
  logic [7:0]     rx_tag    = '0;
  logic [31:0]    rx_data   = '0;
  logic [127:0]   rc_tdata  = '0;
  logic [3:0]     rc_tkeep  = '0;
  logic           rc_tlast  = 1'b0;
  logic           rc_tvalid = 1'b0;
  logic           rc_tready;
  logic           rx_success;
  logic           rx_fail;
  logic [2:0]     fail_code;
  logic [UW-1:0]  unexp_cnt;
  logic           armed;

  cpl_checker #(.TCQ(1), .TIMEOUT_CYCLES(T), .UNEXP_W(UW)) dut (
    .user_clk   (user_clk),
    .reset_n    (reset_n),
    .tx_start   (tx_start),
    .rx_type    (rx_type),
    .rx_tag     (rx_tag),
    .rx_data    (rx_data),
    .rc_tdata   (rc_tdata),
    .rc_tkeep   (rc_tkeep),
    .rc_tlast   (rc_tlast),
    .rc_tvalid  (rc_tvalid),
    .rc_tready  (rc_tready),
    .rx_success (rx_success),
    .rx_fail    (rx_fail),
    .fail_code  (fail_code),
    .unexp_cnt  (unexp_cnt),
    .armed      (armed)
  );

  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  bit          m_ready = 0, m_succ = 0, m_fail = 0;
  bit [2:0]    m_fc = 0;
  int unsigned m_unexp = 0;
  bit          m_req = 0, m_type = 0, m_first = 0;
  bit [7:0]    m_tag = 0;
  bit [31:0]   m_data = 0;
  longint      cyc = 0, m_deadline = 0;
  bit          m_in_tlp = 0, m_ours = 0, m_done = 0;
  bit [2:0]    m_code = 0;

  function automatic bit [2:0] expect_code(input logic [127:0] d, input logic [3:0] k,
                                           input bit typ, input bit first, input bit [31:0] ed);
    if (d[45:43] != 3'd0) return 3'd1;
    if (d[46]) return 3'd2;
    if (d[15:12] != 4'd0) return 3'd3;
    if (typ ? (d[42:32] == 11'd0) : (d[42:32] != 11'd0)) return 3'd4;
    if (typ && first && k[3] && d[127:96] != ed) return 3'd5;
    return 3'd0;
  endfunction

  task automatic m_close(input bit [2:0] c, input bit done);
    if (c != 3'd0) begin
      m_fail = 1; m_fc = c; m_req = 0;
    end else if (done) begin
      m_succ = 1; m_req = 0;
    end else begin
      m_first = 0;
    end
  endtask

  initial begin : model
    bit [2:0] c;
    forever begin
      @(posedge user_clk or negedge reset_n);
      if (!reset_n) begin
        m_ready = 0; m_succ = 0; m_fail = 0; m_fc = 0; m_unexp = 0;
        m_req = 0; m_in_tlp = 0; m_ours = 0;
      end else begin
        cyc++;
        m_succ = 0; m_fail = 0;
        if (rc_tvalid && m_ready) begin
          if (!m_in_tlp) begin
            if (m_req && rc_tdata[71:64] == m_tag) begin
              c = expect_code(rc_tdata, rc_tkeep, m_type, m_first, m_data);
              if (rc_tlast) m_close(c, rc_tdata[30]);
              else begin m_ours = 1; m_code = c; m_done = rc_tdata[30]; end
            end else if (m_unexp < UMAX) begin
              m_unexp++;
            end
            m_in_tlp = !rc_tlast;
          end else if (rc_tlast) begin
            m_in_tlp = 0;
            if (m_ours) begin m_ours = 0; m_close(m_code, m_done); end
          end
        end
        if (m_req && cyc == m_deadline) begin
          m_fail = 1; m_fc = 3'd6; m_req = 0; m_ours = 0;
        end
        if (tx_start) begin
          m_req = 1; m_type = rx_type; m_tag = rx_tag; m_data = rx_data;
          m_first = 1; m_ours = 0; m_deadline = cyc + T;
          if (!m_fail) m_fc = 0;
        end
        m_ready = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin : compare
    forever begin
      @(negedge user_clk);
      if (chk_en) begin
        check("rx_success", 32'(rx_success), 32'(m_succ));
        check("rx_fail",    32'(rx_fail),    32'(m_fail));
        check("fail_code",  32'(fail_code),  32'(m_fc));
        check("unexp_cnt",  32'(unexp_cnt),  32'(m_unexp));
        check("armed",      32'(armed),      32'(m_req));
        check("rc_tready",  32'(rc_tready),  32'(m_ready));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] desc(input logic [7:0] tag, input logic [2:0] st,
                                        input logic po, input logic [3:0] ec, input logic done,
                                        input logic [10:0] dwc, input logic [31:0] data);
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[15:12]  = ec;
    d[30]     = done;
    d[42:32]  = dwc;
    d[45:43]  = st;
    d[46]     = po;
    d[71:64]  = tag;
    d[127:96] = data;
    return d;
  endfunction

  task automatic idle();
    @(negedge user_clk);
    rc_tvalid = 1'b0; rc_tlast = 1'b0; tx_start = 1'b0;
  endtask

  task automatic arm(input bit t, input bit [7:0] tag, input bit [31:0] data);
    @(negedge user_clk);
    tx_start = 1'b1; rx_type = t; rx_tag = tag; rx_data = data;
    rc_tvalid = 1'b0; rc_tlast = 1'b0;
    @(negedge user_clk);
    tx_start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic [3:0] k, input logic last);
    @(negedge user_clk);
    tx_start = 1'b0; rc_tdata = d; rc_tkeep = k; rc_tlast = last; rc_tvalid = 1'b1;
  endtask

  task automatic send_rand_tlp(input bit typ, input bit [7:0] etag, input bit [31:0] edata);
    bit [7:0]  tag;
    bit [2:0]  st;
    bit        po, done, want_data;
    bit [3:0]  ec;
    bit [10:0] dwc;
    bit [31:0] data;
    int        nb;
    tag       = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 3)) : etag;
    st        = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    po        = ($urandom_range(0, 9) == 0);
    ec        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    want_data = ($urandom_range(0, 9) == 0) ? !typ : typ;
    dwc       = want_data ? 11'($urandom_range(1, 2047)) : 11'd0;
    data      = ($urandom_range(0, 4) == 0) ? $urandom : edata;
    done      = ($urandom_range(0, 2) != 0);
    nb        = $urandom_range(1, 3);
    for (int i = 0; i < nb; i++) begin
      if (i == 0) send_beat(desc(tag, st, po, ec, done, dwc, data), 4'($urandom), (nb == 1));
      else        send_beat({$urandom, $urandom, $urandom, $urandom}, 4'($urandom), (i == nb - 1));
      if (i != nb - 1 && $urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit        cur_type;
    bit [7:0]  cur_tag;
    bit [31:0] cur_data;

    #12 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_armed", 32'(armed), 32'd0);
    check("rst_tready", 32'(rc_tready), 32'd0);
    check("rst_unexp", 32'(unexp_cnt), 32'd0);
    repeat (3) @(negedge user_clk);
    reset_n = 1'b1;
    check("tready_pre", 32'(rc_tready), 32'd0);
    @(negedge user_clk);
    check("tready_rise", 32'(rc_tready), 32'd1);
    idle();

    // Good single-beat CplD.
    arm(1'b1, 8'h05, 32'h12345678);
    check("t1_armed", 32'(armed), 32'd1);
    send_beat(desc(8'h05, 3'd0, 1'b0, 4'd0, 1'b1, 11'd1, 32'h12345678), 4'hF, 1'b1);
    idle();
    check("t1_success", 32'(rx_success), 32'd1);
    check("t1_code", 32'(fail_code), 32'd0);
    check("t1_armed_drop", 32'(armed), 32'd0);
    idle();
    check("t1_one_cycle", 32'(rx_success), 32'd0);

    // Data mismatch.
    arm(1'b1, 8'h05, 32'h12345678);
    send_beat(desc(8'h05, 3'd0, 1'b0, 4'd0, 1'b1, 11'd1, 32'h12345679), 4'hF, 1'b1);
    idle();
    check("t2_fail", 32'(rx_fail), 32'd1);
    check("t2_code", 32'(fail_code), 32'd5);

    // Unexpected tag then the right one.
    arm(1'b1, 8'h07, 32'hCAFE0001);
    send_beat(desc(8'h06, 3'd0, 1'b0, 4'd0, 1'b1, 11'd1, 32'hCAFE0001), 4'hF, 1'b1);
    idle();
    check("t3_unexp", 32'(unexp_cnt), 32'd1);
    check("t3_still_armed", 32'(armed), 32'd1);
    send_beat(desc(8'h07, 3'd0, 1'b0, 4'd0, 1'b1, 11'd1, 32'hCAFE0001), 4'hF, 1'b1);
    idle();
    check("t3_success", 32'(rx_success), 32'd1);

    // Split completion: two fragments, only the first is data-checked.
    arm(1'b1, 8'h08, 32'hA5A5_0F0F);
    send_beat(desc(8'h08, 3'd0, 1'b0, 4'd0, 1'b0, 11'd8, 32'hA5A5_0F0F), 4'hF, 1'b0);
    send_beat({$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b1);
    idle();
    check("t4_no_pulse", 32'({rx_success, rx_fail}), 32'd0);
    check("t4_armed", 32'(armed), 32'd1);
    send_beat(desc(8'h08, 3'd0, 1'b0, 4'd0, 1'b1, 11'd4, 32'h0BAD_0BAD), 4'hF, 1'b1);
    idle();
    check("t4_success", 32'(rx_success), 32'd1);

    // Timeout exactly T cycles after arm, then a late completion.
    arm(1'b1, 8'h09, 32'h1);
    repeat (T - 1) @(negedge user_clk);
    check("t5_not_yet", 32'(rx_fail), 32'd0);
    @(negedge user_clk);
    check("t5_timeout", 32'(rx_fail), 32'd1);
    check("t5_code", 32'(fail_code), 32'd6);
    check("t5_disarm", 32'(armed), 32'd0);
    send_beat(desc(8'h09, 3'd0, 1'b0, 4'd0, 1'b1, 11'd1, 32'h1), 4'hF, 1'b1);
    idle();
    check("t5_late_unexp", 32'(unexp_cnt), 32'd2);

    // Status beats poison in priority.
    arm(1'b0, 8'h0A, 32'h0);
    send_beat(desc(8'h0A, 3'd1, 1'b1, 4'd0, 1'b1, 11'd0, 32'h0), 4'h7, 1'b1);
    idle();
    check("t6_fail", 32'(rx_fail), 32'd1);
    check("t6_code", 32'(fail_code), 32'd1);

    // Reset in the middle of our own TLP.
    arm(1'b1, 8'h0B, 32'h55);
    send_beat(desc(8'h0B, 3'd0, 1'b0, 4'd0, 1'b1, 11'd4, 32'h55), 4'hF, 1'b0);
    idle();
    #2 reset_n = 1'b0;
    #1;
    check("t7_armed", 32'(armed), 32'd0);
    check("t7_unexp", 32'(unexp_cnt), 32'd0);
    check("t7_tready", 32'(rc_tready), 32'd0);
    @(negedge user_clk);
    @(negedge user_clk);
    reset_n = 1'b1;
    idle();
    idle();
    send_beat({$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b1);
    idle();
    check("t7_new_first", 32'(unexp_cnt), 32'd1);
    check("t7_no_pulse", 32'({rx_success, rx_fail}), 32'd0);

    // Randomized traffic.
    cur_type = 1'b1; cur_tag = 8'h00; cur_data = 32'h0;
    repeat (250) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        cur_type = 1'($urandom);
        cur_tag  = 8'($urandom_range(0, 3));
        cur_data = $urandom;
        arm(cur_type, cur_tag, cur_data);
      end else if (r < 9) begin
        send_rand_tlp(cur_type, cur_tag, cur_data);
      end else begin
        repeat ($urandom_range(20, 110)) idle();
      end
      repeat ($urandom_range(0, 2)) idle();
    end

    // Saturation of the unexpected counter once disarmed.
    repeat (T + 5) idle();
    repeat (20) begin
      send_beat(desc(8'($urandom), 3'd0, 1'b0, 4'd0, 1'b1, 11'd1, $urandom), 4'hF, 1'b1);
    end
    idle();
    check("sat_unexp", 32'(unexp_cnt), 32'(UMAX));
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
